// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC message widths, field positions and emit states
// Purpose: common constants for the check node unit and its interface.
// Ports: none (package).
package ldpc_pkg;
   localparam int MAG_W     = 4;
   localparam int MSG_IN_W  = MAG_W + 2;   // {hard decision, sign, magnitude}
   localparam int MSG_OUT_W = MAG_W + 1;   // {sign, magnitude}
   localparam int HD_BIT    = MAG_W + 1;
   localparam int SGN_BIT   = MAG_W;
   localparam logic [MAG_W-1:0] MAG_MAX = '1;

   typedef enum logic {ST_IDLE, ST_EMIT} emit_state_t;
endpackage

// File: rtl/cnu_min_sum_if.sv
// rtl/cnu_min_sum_if.sv - message streams between variable node stage and check node unit
// Purpose: groups the input and output handshakes of cnu_min_sum.
// Ports: in_valid/in_ready/in_msg (VN -> CNU), out_valid/out_ready/out_msg/out_last (CNU -> VN).
//   slave modport is the CNU side, master modport is the driving/consuming side.
interface cnu_min_sum_if;
   import ldpc_pkg::*;
   logic                 in_valid;
   logic                 in_ready;
   logic [MSG_IN_W-1:0]  in_msg;
   logic                 out_valid;
   logic                 out_ready;
   logic [MSG_OUT_W-1:0] out_msg;
   logic                 out_last;

   modport slave  (input in_valid, in_msg, out_ready,
                   output in_ready, out_valid, out_msg, out_last);
   modport master (output in_valid, in_msg, out_ready,
                   input in_ready, out_valid, out_msg, out_last);
endinterface

// File: rtl/cnu_min_sum_tracker.sv
// rtl/cnu_min_sum_tracker.sv - collect-side min1/min2/idx/sign accumulator
// Purpose: tracks the two smallest magnitudes, the edge of the smallest, the
//   running sign parity and per-edge signs of the row being collected.
// Ports: clk, rst; init (return to empty row, wins over upd); upd with k/mag/sgn
//   (one accepted edge); cur_* (registered row state); nxt_* (state including
//   this cycle's update, used when a row closes on the current accept).
module cnu_min_tracker
   import ldpc_pkg::*;
#(
   parameter  int DEG   = 6,
   localparam int IDX_W = $clog2(DEG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             upd,
   input  logic [IDX_W-1:0] k,
   input  logic [MAG_W-1:0] mag,
   input  logic             sgn,
   output logic [MAG_W-1:0] cur_min1,
   output logic [MAG_W-1:0] cur_min2,
   output logic [IDX_W-1:0] cur_idx,
   output logic             cur_sgn,
   output logic [DEG-1:0]   cur_vec,
   output logic [MAG_W-1:0] nxt_min1,
   output logic [MAG_W-1:0] nxt_min2,
   output logic [IDX_W-1:0] nxt_idx,
   output logic             nxt_sgn,
   output logic [DEG-1:0]   nxt_vec
);
   logic [MAG_W-1:0] min1_q, min1_d, min2_q, min2_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             sgn_q, sgn_d;
   logic [DEG-1:0]   vec_q, vec_d;

   always_comb begin
      nxt_min1 = min1_q;
      nxt_min2 = min2_q;
      nxt_idx  = idx_q;
      nxt_sgn  = sgn_q;
      nxt_vec  = vec_q;
      if (upd) begin
         // strict compares: a tie with min1 lands in min2
         if (mag < min1_q) begin
            nxt_min2 = min1_q;
            nxt_min1 = mag;
            nxt_idx  = k;
         end else if (mag < min2_q) begin
            nxt_min2 = mag;
         end
         nxt_sgn    = sgn_q ^ sgn;
         nxt_vec[k] = sgn;
      end
      min1_d = init ? MAG_MAX : nxt_min1;
      min2_d = init ? MAG_MAX : nxt_min2;
      idx_d  = init ? '0      : nxt_idx;
      sgn_d  = init ? 1'b0    : nxt_sgn;
      vec_d  = init ? '0      : nxt_vec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min1_q <= MAG_MAX;
         min2_q <= MAG_MAX;
         idx_q  <= '0;
         sgn_q  <= 1'b0;
         vec_q  <= '0;
      end else begin
         min1_q <= min1_d;
         min2_q <= min2_d;
         idx_q  <= idx_d;
         sgn_q  <= sgn_d;
         vec_q  <= vec_d;
      end
   end

   assign cur_min1 = min1_q;
   assign cur_min2 = min2_q;
   assign cur_idx  = idx_q;
   assign cur_sgn  = sgn_q;
   assign cur_vec  = vec_q;
endmodule

// File: rtl/cnu_min_sum.sv
// rtl/cnu_min_sum.sv - ping-pong min-sum check node unit
// Purpose: collects DEG edge messages of one check row while emitting the
//   previous row's check-to-variable messages serially.
// Ports: clk, rst (sync, active-high); bus (cnu_min_sum_if.slave): in_* edge
//   messages in, out_* sign-magnitude results out, out_last on the DEG-th.
module cnu_min_sum
   import ldpc_pkg::*;
#(
   parameter int DEG    = 6,
   parameter int OFFSET = 0
) (
   input logic            clk,
   input logic            rst,
   cnu_min_sum_if.slave   bus
);
   localparam int               IDX_W  = $clog2(DEG);
   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(DEG - 1);
   localparam logic [MAG_W-1:0] OFF    = MAG_W'(OFFSET);

   logic [IDX_W-1:0] cnt_q, cnt_d, j_q, j_d;
   logic             full_q, full_d;        // completed row waiting for the emit bank
   emit_state_t      state_q, state_d;
   logic [MAG_W-1:0] b_min1_q, b_min1_d, b_min2_q, b_min2_d;
   logic [IDX_W-1:0] b_idx_q, b_idx_d;
   logic             b_sgn_q, b_sgn_d;
   logic [DEG-1:0]   b_vec_q, b_vec_d;

   logic accept, last_acc, hs, emit_done, bank_free, xfer_new, xfer_held, xfer;
   logic [MAG_W-1:0] cur_min1, cur_min2, nxt_min1, nxt_min2, mag_sel, mag_off;
   logic [IDX_W-1:0] cur_idx, nxt_idx;
   logic             cur_sgn, nxt_sgn;
   logic [DEG-1:0]   cur_vec, nxt_vec;

   cnu_min_tracker #(.DEG(DEG)) u_tracker (
      .clk(clk), .rst(rst), .init(xfer), .upd(accept), .k(cnt_q),
      .mag(bus.in_msg[MAG_W-1:0]), .sgn(bus.in_msg[SGN_BIT]),
      .cur_min1(cur_min1), .cur_min2(cur_min2), .cur_idx(cur_idx),
      .cur_sgn(cur_sgn), .cur_vec(cur_vec),
      .nxt_min1(nxt_min1), .nxt_min2(nxt_min2), .nxt_idx(nxt_idx),
      .nxt_sgn(nxt_sgn), .nxt_vec(nxt_vec)
   );

   always_comb begin
      accept    = bus.in_valid && !full_q;
      last_acc  = accept && (cnt_q == K_LAST);
      hs        = (state_q == ST_EMIT) && bus.out_ready;
      emit_done = hs && (j_q == K_LAST);
      // bank is reusable if idle or handing over its final message this cycle
      bank_free = (state_q == ST_IDLE) || emit_done;
      xfer_new  = last_acc && bank_free;
      xfer_held = full_q && bank_free;
      xfer      = xfer_new || xfer_held;

      cnt_d    = accept ? ((cnt_q == K_LAST) ? '0 : cnt_q + IDX_W'(1)) : cnt_q;
      full_d   = xfer_held ? 1'b0 : ((last_acc && !bank_free) ? 1'b1 : full_q);
      state_d  = xfer ? ST_EMIT : (emit_done ? ST_IDLE : state_q);
      j_d      = xfer ? '0 : (hs ? j_q + IDX_W'(1) : j_q);

      b_min1_d = b_min1_q;
      b_min2_d = b_min2_q;
      b_idx_d  = b_idx_q;
      b_sgn_d  = b_sgn_q;
      b_vec_d  = b_vec_q;
      if (xfer_new) begin
         b_min1_d = nxt_min1;
         b_min2_d = nxt_min2;
         b_idx_d  = nxt_idx;
         b_sgn_d  = nxt_sgn;
         b_vec_d  = nxt_vec;
      end else if (xfer_held) begin
         b_min1_d = cur_min1;
         b_min2_d = cur_min2;
         b_idx_d  = cur_idx;
         b_sgn_d  = cur_sgn;
         b_vec_d  = cur_vec;
      end

      // the edge holding min1 gets min2 (minimum over all other edges)
      mag_sel = (j_q == b_idx_q) ? b_min2_q : b_min1_q;
      mag_off = (mag_sel > OFF) ? mag_sel - OFF : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         full_q   <= 1'b0;
         state_q  <= ST_IDLE;
         j_q      <= '0;
         b_min1_q <= '0;
         b_min2_q <= '0;
         b_idx_q  <= '0;
         b_sgn_q  <= 1'b0;
         b_vec_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         full_q   <= full_d;
         state_q  <= state_d;
         j_q      <= j_d;
         b_min1_q <= b_min1_d;
         b_min2_q <= b_min2_d;
         b_idx_q  <= b_idx_d;
         b_sgn_q  <= b_sgn_d;
         b_vec_q  <= b_vec_d;
      end
   end

   assign bus.in_ready  = !full_q;
   assign bus.out_valid = (state_q == ST_EMIT);
   assign bus.out_msg   = (state_q == ST_EMIT) ? {b_sgn_q ^ b_vec_q[j_q], mag_off} : '0;
   assign bus.out_last  = (state_q == ST_EMIT) && (j_q == K_LAST);
endmodule

// File: tb/tb_cnu_min_sum.sv
// tb/tb_cnu_min_sum.sv - self-checking bench for cnu_min_sum (OFFSET 0 and 1 side by side)
module tb_cnu_min_sum;
   import ldpc_pkg::*;

   logic clk, rst;
   logic in_valid, out_ready;
   logic [MSG_IN_W-1:0] in_msg;
   int checks, errors, cyc, stalls;
   int exp0[$], exp1[$], hs_cyc[$];
   bit rnd_ready;
   bit held_v[2];
   logic [4:0] held_m[2];

   cnu_min_sum_if b0();
   cnu_min_sum_if b1();
   assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
   assign b0.in_msg = in_msg;      assign b1.in_msg = in_msg;
   assign b0.out_ready = out_ready; assign b1.out_ready = out_ready;

   cnu_min_sum #(.DEG(6), .OFFSET(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
   cnu_min_sum #(.DEG(6), .OFFSET(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   initial begin
      cyc = 0;
      forever begin @(posedge clk); cyc++; end
   end
   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Each output of a check node is the min over all OTHER edges' magnitudes,
   // its sign the parity of all OTHER edges' signs.
   task automatic push_row(input int m[6], input int s[6]);
      for (int j = 0; j < 6; j++) begin
         int mn, sg;
         mn = 1000; sg = 0;
         for (int k = 0; k < 6; k++)
            if (k != j) begin
               if (m[k] < mn) mn = m[k];
               sg ^= s[k];
            end
         for (int off = 0; off < 2; off++) begin
            int mm, e;
            mm = (mn > off) ? mn - off : 0;
            e = ((j == 5) ? 256 : 0) + sg * 16 + mm;
            if (off == 0) exp0.push_back(e); else exp1.push_back(e);
         end
      end
   endtask

   task automatic send(input int mag, input int sg);
      int g;
      logic [3:0] m4;
      m4 = mag[3:0];
      in_valid = 1;
      in_msg = {1'($urandom_range(0, 1)), sg[0], m4};
      g = 0;
      while (!b0.in_ready && g < 200) begin
         @(negedge clk);
         g++; stalls++;
      end
      if (g >= 200) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic send_row(input int m[6], input int s[6], input int n, input bit gap);
      if (n == 6) push_row(m, s);
      for (int i = 0; i < n; i++) begin
         if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
         send(m[i], s[i]);
      end
   endtask

   task automatic wait_drain(input int bound);
      int g;
      g = 0;
      while (!(exp0.size() == 0 && exp1.size() == 0 && !b0.out_valid) && g < bound) begin
         @(negedge clk);
         g++;
      end
      if (g >= bound) chk("drain_timeout", 0, 1);
   endtask

   task automatic mon(input int id, input logic v, input logic [4:0] msg, input logic last);
      int e;
      if (held_v[id] && v) chk(id ? "hold1" : "hold0", msg, held_m[id]);
      if (v && out_ready) begin
         if (id == 0) begin
            hs_cyc.push_back(cyc);
            if (exp0.size() == 0) chk("sb0_extra", 1, 0);
            else begin
               e = exp0.pop_front();
               chk("msg0", msg, e[4:0]);
               chk("last0", last, e[8]);
            end
         end else begin
            if (exp1.size() == 0) chk("sb1_extra", 1, 0);
            else begin
               e = exp1.pop_front();
               chk("msg1", msg, e[4:0]);
               chk("last1", last, e[8]);
            end
         end
      end
      held_v[id] = v && !out_ready;
      held_m[id] = msg;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            held_v[0] = 0; held_v[1] = 0;
         end else begin
            mon(0, b0.out_valid, b0.out_msg, b0.out_last);
            mon(1, b1.out_valid, b1.out_msg, b1.out_last);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int m[6], s[6], z[6], g, span;
      checks = 0; errors = 0; stalls = 0;
      rst = 1; in_valid = 0; in_msg = '0; out_ready = 1; rnd_ready = 0;
      z = '{0, 0, 0, 0, 0, 0};
      repeat (3) @(negedge clk);
      chk("rst_in_ready", b0.in_ready, 1);
      chk("rst_out_valid", b0.out_valid, 0);
      chk("rst_out_msg", b0.out_msg, 0);
      chk("rst_out_last", b0.out_last, 0);
      chk("rst_out_valid1", b1.out_valid, 0);
      rst = 0;
      @(negedge clk);

      // row with a repeated minimum, first output one cycle after 6th accept
      m = '{5, 3, 9, 3, 12, 7};
      push_row(m, z);
      for (int i = 0; i < 5; i++) send(m[i], 0);
      chk("t1_pre_valid", b0.out_valid, 0);
      send(m[5], 0);
      chk("t1_latency", b0.out_valid, 1);
      wait_drain(100);

      // two rows back to back, no stalls and no bubbles
      hs_cyc.delete(); stalls = 0;
      m = '{8, 2, 6, 4, 10, 11}; s = '{1, 0, 0, 1, 0, 0};
      send_row(m, s, 6, 0);
      m = '{3, 5, 7, 9, 11, 13}; s = '{0, 1, 1, 0, 1, 0};
      send_row(m, s, 6, 0);
      wait_drain(100);
      chk("t2_stalls", stalls, 0);
      chk("t2_count", hs_cyc.size(), 12);
      span = (hs_cyc.size() >= 12) ? hs_cyc[11] - hs_cyc[0] : -1;
      chk("t2_span", span, 11);

      // downstream stall while a second row completes
      hs_cyc.delete();
      out_ready = 0;
      m = '{1, 0, 4, 4, 15, 15}; s = '{1, 1, 0, 1, 0, 0};
      send_row(m, s, 6, 0);
      m = '{7, 7, 7, 7, 7, 7}; s = '{0, 0, 1, 0, 0, 1};
      send_row(m, s, 6, 0);
      chk("t3_held0", b0.in_ready, 0);
      chk("t3_held1", b1.in_ready, 0);
      repeat (3) @(negedge clk);
      chk("t3_no_hs", hs_cyc.size(), 0);
      out_ready = 1;
      g = 0;
      while (!(b0.out_valid && b0.out_last) && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("t3_found_last", g < 50, 1);
      chk("t3_ready_before", b0.in_ready, 0);
      @(negedge clk);
      chk("t3_ready_after", b0.in_ready, 1);
      chk("t3_no_bubble", b0.out_valid, 1);
      wait_drain(100);
      chk("t3_count", hs_cyc.size(), 12);
      span = (hs_cyc.size() >= 12) ? hs_cyc[11] - hs_cyc[0] : -1;
      chk("t3_span", span, 11);

      // reset mid-collect and mid-emit
      for (int i = 0; i < 6; i++) begin m[i] = $urandom_range(0, 15); s[i] = $urandom_range(0, 1); end
      send_row(m, s, 6, 0);
      send_row(m, s, 3, 0);
      rst = 1;
      exp0.delete(); exp1.delete();
      @(negedge clk);
      rst = 0;
      chk("t6_out_valid", b0.out_valid, 0);
      chk("t6_in_ready", b0.in_ready, 1);
      chk("t6_out_valid1", b1.out_valid, 0);
      chk("t6_in_ready1", b1.in_ready, 1);
      for (int i = 0; i < 6; i++) begin m[i] = $urandom_range(0, 15); s[i] = $urandom_range(0, 1); end
      send_row(m, s, 6, 0);
      wait_drain(100);

      // random rows with random gaps and random downstream backpressure
      rnd_ready = 1;
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 6; i++) begin
            m[i] = $urandom_range(0, 15);
            s[i] = $urandom_range(0, 1);
         end
         send_row(m, s, 6, 1);
      end
      rnd_ready = 0;
      @(negedge clk);
      out_ready = 1;
      wait_drain(400);

      chk("sb0_left", exp0.size(), 0);
      chk("sb1_left", exp1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cnu_min_sum.md
Name: cnu_min_sum

Overview:
- Check Node Unit. Consumes the 6-bit extrinsic messages produced by the variable node stage, one edge per cycle, for one check row of degree DEG.
- Computes min-sum check-to-variable messages and returns them serially as 5-bit sign-magnitude words, the format the variable node stage takes on its X inputs.
- Ping-pong structured: one row is collected while the previous row is emitted.

Parameters:
- DEG, 6, check node degree (edges per row), must be >= 2.
- MAG_W, 4, magnitude width of messages.
- OFFSET, 0, offset-min-sum correction subtracted from output magnitude, saturating at 0.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_msg carries a valid edge message.
- in_ready  output  1  block accepts in_msg this cycle.
- in_msg  input  MAG_W+2  variable node message: bit MAG_W+1 is the hard decision (ignored), bit MAG_W is the sign, bits MAG_W-1:0 are the magnitude.
- out_valid  output  1  out_msg is valid.
- out_ready  input  1  downstream accepts out_msg.
- out_msg  output  MAG_W+1  check-to-variable message: bit MAG_W is the sign, bits MAG_W-1:0 are the magnitude.
- out_last  output  1  high with the DEG-th (final) message of a row.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, out_msg=0, out_last=0. Collect counter=0, min1=min2=2^MAG_W-1, idx=0, sign accumulator=0, emit bank empty. Reset mid-row discards partial collect and emit state.
- Input accept: a message is accepted when in_valid && in_ready. Edge index k = collect counter (0..DEG-1), incremented per accept.
- Collect update per accepted mag m, sign s:
  - If m < min1: min2 <= min1, min1 <= m, idx <= k.
  - Else if m < min2: min2 <= m.
  - Ties with min1 therefore land in min2.
  - sgn_all <= sgn_all ^ s; sign_vec[k] <= s.
- Row close: on the accept with k = DEG-1, the final-updated {min1, min2, idx, sgn_all, sign_vec} are copied to the emit bank if the emit bank is empty, or is emitting its last message with out_ready=1 that same cycle. Collect state is then re-initialised to its reset values.
  - Otherwise the collect bank holds the completed row and in_ready=0 until the emit bank frees. Transfer then happens on the freeing cycle and in_ready returns to 1 the next cycle.
- in_ready=0 only in that held state. Messages presented while in_ready=0 are not consumed.
- Emit FSM: states IDLE, EMIT.
  - IDLE -> EMIT on transfer. out_valid=1 from the cycle after the transfer (latency: first output one cycle after the last input is accepted).
  - In EMIT, message j (0..DEG-1): mag = (j==idx ? min2 : min1); mag = (mag > OFFSET) ? mag-OFFSET : 0; sign = sgn_all ^ sign_vec[j]; out_msg = {sign, mag}.
  - j advances only on out_valid && out_ready. out_msg and out_last hold stable while out_ready=0.
  - out_last=1 when j=DEG-1. After that handshake: if a completed row is pending (same-cycle transfer), stay in EMIT with j=0 and no bubble; else go to IDLE with out_valid=0.
- Throughput: one edge per cycle sustained when out_ready=1 continuously. No bubbles between rows.
- Arithmetic: all comparisons unsigned on MAG_W bits. No overflow possible; saturation only at OFFSET subtraction.

Decomposition:
- Shared package ldpc_pkg: MAG_W; message widths MSG_IN_W=MAG_W+2, MSG_OUT_W=MAG_W+1; bit-position constants for the sign and hard-decision fields; MAG_MAX.
- One natural sub-module: cnu_min_tracker, the collect-side min1/min2/idx/sign accumulator with init and update ports. The emit FSM stays in the top module.

Test Plan:
- DEG=6, OFFSET=0, row mags 5,3,9,3,12,7, all signs 0, out_ready=1 -> outputs mags 3,3,3,3,3,3 (idx=1, min2=3), signs 0, out_last on 6th; first out_valid the cycle after the 6th accept.
- Mags 8,2,6,4,10,11 with signs 1,0,0,1,0,0 -> sgn_all=0; out mags 2,4,2,2,2,2; out signs 1,0,0,1,0,0.
- Two back-to-back rows with out_ready=1 -> in_ready stays 1, 12 consecutive out_valid cycles, out_last at cycles 6 and 12.
- out_ready=0 during first row's emit while second row completes -> in_ready=0 after 12th accept, out_msg stable; raising out_ready drains row 1 then row 2 with no bubble; in_ready=1 the cycle after the transfer.
- OFFSET=1, mags 1,0,4,4,15,15 -> min1=0 (idx=1), min2=1; out mags 0,0,0,0,0,0; OFFSET=1 with mags 3,5,... -> mags 2 and 4 after saturating subtraction.
- rst asserted after 3 accepts and mid-emit -> next cycle out_valid=0, in_ready=1; a fresh 6-message row then produces correct results with no residue from the aborted row.
